// File: rtl/lfsr_checker.sv
// Receive-side checker for the 9-bit XNOR LFSR (x^9+x^5+1) pattern stream.
// Locks onto the stream, predicts each next word and counts mismatches while locked.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_err,
  input  logic             in_valid,
  input  logic [8:0]       in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);
  localparam logic [8:0] LOCKUP = 9'h1FF;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [8:0] lfsr_next(input logic [8:0] q);
    return {q[7:0], ~(q[8] ^ q[4])};
  endfunction

  state_e           state_q, state_d;
  logic             seeded_q, seeded_d;
  logic [8:0]       pred_q, pred_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // The lock-up word can never be a valid seed; everything else seeds.
  logic       seed_ok;
  logic [8:0] seed_pred;
  assign seed_ok   = (in_data != LOCKUP);
  assign seed_pred = lfsr_next(in_data);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    seeded_d    = seeded_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (seeded_q && (in_data == pred_q)) begin
            pred_d      = lfsr_next(pred_q);
            match_cnt_d = match_cnt_q + MW'(1);
            if (match_cnt_d == MW'(LOCK_CNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
            seeded_d    = seed_ok;
            if (seed_ok) pred_d = seed_pred;
          end
        end
        LOCKED: begin
          // Free-runs on its own prediction; bad data never resyncs it.
          pred_d = lfsr_next(pred_q);
          if (in_data == pred_q) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
            miss_cnt_d = miss_cnt_q + LW'(1);
            if (miss_cnt_d == LW'(LOSS_CNT)) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              seeded_d    = seed_ok;
              if (seed_ok) pred_d = seed_pred;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear_err) err_count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      seeded_q    <= 1'b0;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      seeded_q    <= seeded_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: vector table, directed corner sequences,
// and randomized traffic against a behavioural model (two instances: ERR_W=16 and ERR_W=4).
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_err;
  logic       in_valid;
  logic [8:0] in_data;
  logic       locked, err_pulse;
  logic [15:0] err_count;
  logic       locked_s, err_pulse_s;
  logic [3:0] err_count_s;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .clear_err(clear_err), .in_valid(in_valid),
    .in_data(in_data), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut_sat (
    .clk(clk), .reset(reset), .clear_err(clear_err), .in_valid(in_valid),
    .in_data(in_data), .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit m_locked, m_seeded, m_pulse;
  int m_pred, m_run, m_miss, m_err;

  int gen;  // next correct stream word the bench will send

  function automatic int nxt(input int q);
    return ((q * 2) % 512) + ((((q >> 8) & 1) == ((q >> 4) & 1)) ? 1 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_pulse = 0;
    m_pred = 0; m_run = 0; m_miss = 0; m_err = 0;
  endtask

  task automatic model_seed(input int d);
    m_run = 0;
    if (d != 511) begin
      m_pred = nxt(d);
      m_seeded = 1;
    end else begin
      m_seeded = 0;
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit hit;
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        if (m_seeded && d == m_pred) begin
          m_pred = nxt(m_pred);
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_locked = 1;
            m_miss = 0;
          end
        end else begin
          model_seed(d);
        end
      end else begin
        hit = (d == m_pred);
        m_pred = nxt(m_pred);
        if (hit) m_miss = 0;
        else begin
          m_pulse = 1;
          m_err++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_locked = 0;
            m_miss = 0;
            model_seed(d);
          end
        end
      end
    end
    if (c) m_err = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "/locked"}, 32'(locked), 32'(m_locked));
    check({tag, "/err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    check({tag, "/err_count"}, 32'(err_count), (m_err > 65535) ? 32'd65535 : 32'(m_err));
    check({tag, "/err_count_sat"}, 32'(err_count_s), (m_err > 15) ? 32'd15 : 32'(m_err));
  endtask

  task automatic step(input bit v, input logic [8:0] d, input bit c, input string tag);
    in_valid  = v;
    in_data   = d;
    clear_err = c;
    @(posedge clk);
    model_step(v, int'(d), c);
    #1;
    if (tag != "") compare_model(tag);
  endtask

  task automatic send_good(input string tag);
    step(1'b1, 9'(gen), 1'b0, tag);
    gen = nxt(gen);
  endtask

  typedef struct {
    bit         v;
    logic [8:0] d;
    bit         clr;
    bit         e_locked;
    bit         e_pulse;
    int         e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean lock, gaps, single error, clear
    vecs.push_back('{1, 9'h000, 0, 0, 0, 0});
    vecs.push_back('{1, 9'h001, 0, 0, 0, 0});
    vecs.push_back('{0, 9'h0AA, 0, 0, 0, 0});
    vecs.push_back('{1, 9'h003, 0, 0, 0, 0});
    vecs.push_back('{1, 9'h007, 0, 0, 0, 0});
    vecs.push_back('{1, 9'h00F, 0, 1, 0, 0});
    vecs.push_back('{1, 9'h01F, 0, 1, 0, 0});
    vecs.push_back('{0, 9'h1FF, 0, 1, 0, 0});
    vecs.push_back('{1, 9'h03E, 0, 1, 0, 0});
    vecs.push_back('{1, 9'h07C, 0, 1, 0, 0});
    vecs.push_back('{1, 9'h0F9, 0, 1, 1, 1});
    vecs.push_back('{1, 9'h1F0, 0, 1, 0, 1});
    vecs.push_back('{0, 9'h000, 1, 1, 0, 0});
    vecs.push_back('{1, 9'h1E1, 0, 1, 0, 0});

    reset = 1'b0; clear_err = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].clr, "");
      check($sformatf("vec%0d/locked", i), 32'(locked), 32'(vecs[i].e_locked));
      check($sformatf("vec%0d/err_pulse", i), 32'(err_pulse), 32'(vecs[i].e_pulse));
      check($sformatf("vec%0d/err_count", i), 32'(err_count), 32'(vecs[i].e_err));
      check($sformatf("vec%0d/err_count_sat", i), 32'(err_count_s), 32'(vecs[i].e_err));
    end
    gen = nxt(9'h1E1);

    // Free-run: 600 more words with random gaps
    for (int i = 0; i < 600; i++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 9'($urandom_range(0, 511)), 1'b0, "gap");
      send_good("freerun");
    end
    check("freerun_end/locked", 32'(locked), 32'd1);

    // Loss of lock: three mismatching words, the last one the lock-up word
    step(1'b1, 9'(gen ^ 256), 1'b0, "loss1"); gen = nxt(gen);
    check("loss1/pulse", 32'(err_pulse), 32'd1);
    step(1'b1, 9'(gen ^ 256), 1'b0, "loss2"); gen = nxt(gen);
    check("loss2/locked", 32'(locked), 32'd1);
    step(1'b1, 9'h1FF, 1'b0, "loss3"); gen = nxt(gen);
    check("loss3/pulse", 32'(err_pulse), 32'd1);
    check("loss3/locked", 32'(locked), 32'd0);
    check("loss3/err_count", 32'(err_count), 32'd3);
    gen = 9'h0AA;
    for (int i = 0; i < 4; i++) send_good("relock");
    check("relock4/locked", 32'(locked), 32'd0);
    send_good("relock");
    check("relock5/locked", 32'(locked), 32'd1);

    // Lock-up words ignored after reset
    reset = 1'b0;
    #3;
    model_reset();
    compare_model("reset2");
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 9'h1FF, 1'b0, "lockup1");
    step(1'b1, 9'h1FF, 1'b0, "lockup2");
    gen = 0;
    for (int i = 0; i < 4; i++) send_good("seed");
    check("seed4/locked", 32'(locked), 32'd0);
    send_good("seed");
    check("seed5/locked", 32'(locked), 32'd1);
    step(1'b1, 9'(gen ^ 1), 1'b0, "pre_rst_err"); gen = nxt(gen);
    send_good("pre_rst");
    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst/locked", 32'(locked), 32'd0);
    check("async_rst/err_count", 32'(err_count), 32'd0);
    compare_model("async_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    gen = 9'h0AA;
    for (int i = 0; i < 5; i++) send_good("after_rst");
    check("after_rst/locked", 32'(locked), 32'd1);

    // Saturation: 20 errors separated by matches
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 9'(gen ^ 1), 1'b0, "sat_err"); gen = nxt(gen);
      send_good("sat_ok");
    end
    check("sat/err_count_sat", 32'(err_count_s), 32'hF);
    check("sat/err_count", 32'(err_count), 32'd20);
    step(1'b1, 9'(gen ^ 1), 1'b1, "clr_err"); gen = nxt(gen);
    check("clr/pulse", 32'(err_pulse), 32'd1);
    check("clr/err_count", 32'(err_count), 32'd0);
    check("clr/err_count_sat", 32'(err_count_s), 32'd0);
    check("clr/locked", 32'(locked), 32'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 49) == 0);
      if (r < 20) step(1'b0, 9'($urandom_range(0, 511)), c, "rnd_gap");
      else if (r < 30) begin
        step(1'b1, 9'($urandom_range(0, 511)), c, "rnd_bad");
        if ($urandom_range(0, 1) == 1) gen = nxt(gen);
      end else if (r < 32) step(1'b1, 9'h1FF, c, "rnd_lockup");
      else begin
        step(1'b1, 9'(gen), c, "rnd_good");
        gen = nxt(gen);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
